// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the counter library
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

  // A prescaler of 1 has no state, but still gets a 1-bit width.
  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler emitting a one-cycle tick every PRESCALE enabled cycles
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_pass
      logic unused_in;
      assign unused_in = clk ^ rst_n ^ clear;
      assign tick      = en;
    end else begin : g_cnt
      localparam int PW = presc_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
      end

      assign tick = en && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with one-shot/auto-reload expiry pulse
module countdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  timer_state_e     state;
  logic [WIDTH-1:0] reload;
  logic             mode;
  logic             tick;
  logic             presc_en;
  logic             presc_clear;

  // The prescaler only runs in RUN and restarts from zero on every new countdown.
  assign presc_en    = en && (state == RUN);
  assign presc_clear = (state != RUN) || abort;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .clear(presc_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      reload <= '0;
      mode   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (abort) begin
            count <= '0;
          end else if (start) begin
            if (load_val != '0) begin
              count  <= load_val;
              reload <= load_val;
              mode   <= auto_reload;
              state  <= RUN;
              busy   <= 1'b1;
            end else begin
              count <= '0;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            if (count == WIDTH'(1)) begin
              done <= 1'b1;
              if (mode) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (count != '0) begin
              count <= count - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer at PRESCALE 1 and 3
module tb_countdown_timer;

  typedef struct {
    logic [7:0] c;
    logic       b;
    logic       d;
    logic       p3;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] load_val = '0;
  logic       auto_reload = 1'b0;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] count1, count3;
  logic       busy1, busy3, done1, done3;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic sel3 = 1'b0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .en(en), .abort(abort),
    .count(count1), .busy(busy1), .done(done1)
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .en(en), .abort(abort),
    .count(count3), .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Monitor: one expected entry is consumed per clock edge, just after it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.p3) begin
        check("count_p3", 32'(count3), 32'(e.c));
        check("busy_p3", 32'(busy3), 32'(e.b));
        check("done_p3", 32'(done3), 32'(e.d));
      end else begin
        check("count", 32'(count1), 32'(e.c));
        check("busy", 32'(busy1), 32'(e.b));
        check("done", 32'(done1), 32'(e.d));
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic s, input logic [7:0] lv, input logic ar, input logic e,
                     input logic ab, input logic [7:0] c, input logic b, input logic d);
    exp_t x;
    @(negedge clk);
    start = s; load_val = lv; auto_reload = ar; en = e; abort = ab;
    x.c = c; x.b = b; x.d = d; x.p3 = sel3;
    exp_q.push_back(x);
  endtask

  task automatic idle(input logic [7:0] c, input logic b, input logic d);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, c, b, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; load_val = 0; auto_reload = 0; en = 0; abort = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_count", 32'(count1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_count_p3", 32'(count3), 32'd0);
    do_reset();

    // One-shot from 5 at P=1.
    cyc(1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
    for (int k = 4; k >= 1; k--) idle(8'(k), 1'b1, 1'b0);
    idle(8'd0, 1'b0, 1'b1);
    idle(8'd0, 1'b0, 1'b0);
    drain();

    // P=3, L=2: each value held 3 cycles, done 6 cycles after start.
    do_reset();
    sel3 = 1'b1;
    cyc(1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      if (t < 6) idle(8'(2 - t / 3), 1'b1, 1'b0);
      else       idle(8'd0, 1'b0, 1'b1);
    end
    idle(8'd0, 1'b0, 1'b0);
    drain();
    sel3 = 1'b0;

    // Auto-reload from 3, then abort.
    do_reset();
    cyc(1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      idle(8'd2, 1'b1, 1'b0);
      idle(8'd1, 1'b1, 1'b0);
      idle(8'd3, 1'b1, 1'b1);
    end
    idle(8'd2, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle(8'd0, 1'b0, 1'b0);
    drain();

    // en dropped for 4 cycles mid-countdown from 4, then a zero-load start.
    do_reset();
    cyc(1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0);
    idle(8'd3, 1'b1, 1'b0);
    idle(8'd2, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
    idle(8'd1, 1'b1, 1'b0);
    idle(8'd0, 1'b0, 1'b1);
    cyc(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    idle(8'd0, 1'b0, 1'b0);
    drain();

    // Abort on the expiring tick.
    do_reset();
    cyc(1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    idle(8'd1, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    idle(8'd0, 1'b0, 1'b0);
    drain();

    // Start during RUN is ignored; back-to-back start when busy first reads 0.
    do_reset();
    cyc(1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
    cyc(1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    idle(8'd1, 1'b1, 1'b0);
    idle(8'd0, 1'b0, 1'b1);
    cyc(1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    idle(8'd0, 1'b0, 1'b1);
    cyc(1'b1, 8'd9, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    drain();

    // Full-scale load: no wrap past zero.
    do_reset();
    cyc(1'b1, 8'd255, 1'b0, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
    for (int k = 254; k >= 1; k--) idle(8'(k), 1'b1, 1'b0);
    idle(8'd0, 1'b0, 1'b1);
    idle(8'd0, 1'b0, 1'b0);
    idle(8'd0, 1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-RUN.
    do_reset();
    cyc(1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
    idle(8'd4, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count1), 32'd0);
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_done", 32'(done1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) idle(8'd0, 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
